// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and load/store accesses onto one single-port data memory.
// Arbitration is fixed D-over-IF unless MEM_ARB_RR_EN is defined (round-robin).
module mem_port_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 32,
  parameter int unsigned MEM_DEPTH = 128,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_done,
  output logic          addr_err,
  output logic          busy,
  output logic          memRead,
  output logic          memWrite,
  output logic [AW-1:0] memaddress,
  output logic [DW-1:0] invalue,
  input  logic [DW-1:0] outvalue
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  logic [1:0]    r_state;
  logic          r_id_d;
  logic          r_we;
  logic          r_oor;
  logic [3:0]    r_cnt;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic [AW-1:0] r_memaddr;
  logic [DW-1:0] r_invalue;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_if_done;
  logic          r_d_done;
  logic          r_addr_err;

  logic          w_grant_d;
  logic [AW-1:0] w_sel_addr;
  logic          w_sel_we;
  logic          w_sel_oor;

`ifdef MEM_ARB_RR_EN
  // 1 = D was granted last; on a tie the other requester wins.
  logic r_rr_last_d;

  always_comb w_grant_d = d_req & (~if_req | ~r_rr_last_d);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rr_last_d <= 1'b1;
    end else if (r_state == StIdle && (if_req || d_req)) begin
      r_rr_last_d <= w_grant_d;
    end
  end
`else
  always_comb w_grant_d = d_req;
`endif

  always_comb begin
    w_sel_addr = w_grant_d ? d_addr : if_addr;
    w_sel_we   = w_grant_d & d_we;
    w_sel_oor  = 32'(w_sel_addr) >= MEM_DEPTH;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_id_d     <= 1'b0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
      r_cnt      <= 4'd0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_memaddr  <= '0;
      r_invalue  <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_if_done  <= 1'b0;
      r_d_done   <= 1'b0;
      r_addr_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (if_req || d_req) begin
            // Strobes are registered here so they are high exactly during ISSUE.
            r_id_d    <= w_grant_d;
            r_we      <= w_sel_we;
            r_oor     <= w_sel_oor;
            r_memaddr <= w_sel_addr;
            r_mem_rd  <= ~w_sel_oor & ~w_sel_we;
            r_mem_wr  <= ~w_sel_oor & w_sel_we;
            if (!w_sel_oor && w_sel_we) begin
              r_invalue <= d_wdata;
            end
            r_state <= StIssue;
          end
        end
        StIssue: begin
          r_cnt   <= 4'(MEM_LAT - 1);
          r_state <= StWait;
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            r_addr_err <= r_oor;
            if (r_id_d) begin
              r_d_done <= 1'b1;
              if (!r_we) begin
                r_d_rdata <= r_oor ? '0 : outvalue;
              end
            end else begin
              r_if_done  <= 1'b1;
              r_if_rdata <= r_oor ? '0 : outvalue;
            end
            r_state <= StResp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StResp: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_done    = r_if_done;
  assign d_rdata    = r_d_rdata;
  assign d_done     = r_d_done;
  assign addr_err   = r_addr_err;
  assign busy       = (r_state != StIdle);
  assign memRead    = r_mem_rd;
  assign memWrite   = r_mem_wr;
  assign memaddress = r_memaddr;
  assign invalue    = r_invalue;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model; honours MEM_ARB_RR_EN when defined.
module tb_mem_port_arbiter;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // Main instance, MEM_LAT = 1.
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done, addr_err, busy, memRead, memWrite;
  logic [7:0]  memaddress;
  logic [31:0] invalue;
  logic [31:0] outvalue = '0;

  // Second instance, MEM_LAT = 4, IF side only.
  logic        if_req4 = 1'b0;
  logic [7:0]  if_addr4 = '0;
  logic [31:0] if_rdata4;
  logic        if_done4;
  logic        d_req4 = 1'b0;
  logic        d_we4 = 1'b0;
  logic [7:0]  d_addr4 = '0;
  logic [31:0] d_wdata4 = '0;
  logic [31:0] d_rdata4;
  logic        d_done4, addr_err4, busy4, memRead4, memWrite4;
  logic [7:0]  memaddress4;
  logic [31:0] invalue4;
  logic [31:0] outvalue4 = '0;

  mem_port_arbiter #(.AW(8), .DW(32), .MEM_DEPTH(128), .MEM_LAT(1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .addr_err(addr_err), .busy(busy),
    .memRead(memRead), .memWrite(memWrite), .memaddress(memaddress),
    .invalue(invalue), .outvalue(outvalue)
  );

  mem_port_arbiter #(.AW(8), .DW(32), .MEM_DEPTH(128), .MEM_LAT(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_done(if_done4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4), .d_wdata(d_wdata4),
    .d_rdata(d_rdata4), .d_done(d_done4), .addr_err(addr_err4), .busy(busy4),
    .memRead(memRead4), .memWrite(memWrite4), .memaddress(memaddress4),
    .invalue(invalue4), .outvalue(outvalue4)
  );

  // Memory array models: synchronous, read data held until the next read.
  logic [31:0] mem1 [128] = '{default: 32'h0};
  logic [31:0] mem4 [128] = '{2: 32'hA5A5_0002, default: 32'h0};

  always @(posedge clock) begin
    if (memWrite && memaddress < 8'd128) mem1[memaddress[6:0]] <= invalue;
    if (memRead && memaddress < 8'd128) outvalue <= mem1[memaddress[6:0]];
    if (memRead4 && memaddress4 < 8'd128) outvalue4 <= mem4[memaddress4[6:0]];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model: word array, held read data per port, last-grant pointer.
  logic [31:0] m_mem [128] = '{default: 32'h0};
  logic [31:0] m_if_rd = '0;
  logic [31:0] m_d_rd = '0;
  bit          m_last_d = 1'b1;

  task automatic model_reset();
    m_if_rd = '0;
    m_d_rd = '0;
    m_last_d = 1'b1;
  endtask

  task automatic model_access(input bit is_d, input bit we, input logic [7:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output bit err);
    err = (a >= 8'd128);
    if (we) begin
      if (!err) m_mem[a[6:0]] = wd;
    end else if (is_d) begin
      m_d_rd = err ? 32'h0 : m_mem[a[6:0]];
    end else begin
      m_if_rd = err ? 32'h0 : m_mem[a[6:0]];
    end
    rd = is_d ? m_d_rd : m_if_rd;
    m_last_d = is_d;
  endtask

  function automatic bit model_d_first_on_tie();
`ifdef MEM_ARB_RR_EN
    return !m_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Raise requests in an IDLE cycle and observe until every raised request is done.
  task automatic drive(input bit ifr, input logic [7:0] ia, input bit dr, input bit dwe,
                       input logic [7:0] da, input logic [31:0] dwd,
                       output int il, output int dl, output logic [31:0] idat,
                       output logic [31:0] ddat, output bit ierr, output bit derr,
                       output int nrd, output int nwr, output int nbusy, output bit clash,
                       output logic [7:0] saddr, output logic [31:0] swd);
    il = -1; dl = -1; idat = '0; ddat = '0; ierr = 0; derr = 0;
    nrd = 0; nwr = 0; nbusy = 0; clash = 0; saddr = '0; swd = '0;
    @(negedge clock);
    if_req = ifr; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (memRead) nrd++;
      if (memWrite) nwr++;
      if (memRead || memWrite) begin saddr = memaddress; swd = invalue; end
      if (busy) nbusy++;
      if (if_done && d_done) clash = 1;
      if (if_done) begin il = i; idat = if_rdata; ierr = addr_err; if_req = 0; end
      if (d_done) begin dl = i; ddat = d_rdata; derr = addr_err; d_req = 0; end
      // Request fields are latched, so scrambling them after ISSUE must not matter.
      if (i == 1 && !(ifr && dr)) begin
        if_addr = 8'($urandom); d_addr = 8'($urandom); d_wdata = $urandom; d_we = 1'($urandom);
      end
      if ((!ifr || il >= 0) && (!dr || dl >= 0)) break;
    end
    if_req = 0; d_req = 0;
  endtask

  int il, dl, nrd, nwr, nbusy;
  logic [31:0] idat, ddat, swd, e_idat, e_ddat;
  logic [7:0] saddr;
  bit ierr, derr, clash, e_ierr, e_derr;

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if ({memRead, memWrite, if_done, d_done, addr_err, busy, memaddress, invalue, if_rdata,
         d_rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h want 0", {memRead, memWrite, if_done, d_done,
               addr_err, busy, memaddress, invalue, if_rdata, d_rdata});
    end
    n_vec++;
    if ({memRead4, if_done4, busy4, memaddress4, if_rdata4} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs_lat4 got %h want 0",
               {memRead4, if_done4, busy4, memaddress4, if_rdata4});
    end
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_write();
    model_access(1, 1, 8'h05, 32'hDEADBEEF, e_ddat, e_derr);
    drive(0, 8'h00, 1, 1, 8'h05, 32'hDEADBEEF, il, dl, idat, ddat, ierr, derr, nrd, nwr,
          nbusy, clash, saddr, swd);
    n_vec++; if (dl !== 3) begin n_err++; $display("FAIL write_latency got %0d want 3", dl); end
    n_vec++; if (nwr !== 1 || nrd !== 0) begin
      n_err++; $display("FAIL write_strobes got wr=%0d rd=%0d want wr=1 rd=0", nwr, nrd);
    end
    n_vec++; if (saddr !== 8'h05 || swd !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL write_addr_data got %h/%h want 05/deadbeef", saddr, swd);
    end
    n_vec++; if (ddat !== e_ddat || derr !== e_derr) begin
      n_err++; $display("FAIL write_rdata got %h err=%0b want %h err=%0b", ddat, derr, e_ddat,
                        e_derr);
    end
  endtask

  task automatic test_readback();
    model_access(1, 0, 8'h05, 32'h0, e_ddat, e_derr);
    drive(0, 8'h00, 1, 0, 8'h05, 32'h0, il, dl, idat, ddat, ierr, derr, nrd, nwr, nbusy,
          clash, saddr, swd);
    n_vec++; if (dl !== 3 || nrd !== 1 || nwr !== 0) begin
      n_err++; $display("FAIL readback_timing got lat=%0d rd=%0d wr=%0d want 3/1/0", dl, nrd, nwr);
    end
    n_vec++; if (ddat !== e_ddat) begin
      n_err++; $display("FAIL readback_data got %h want %h", ddat, e_ddat);
    end
    n_vec++; if (il !== -1) begin
      n_err++; $display("FAIL readback_if_quiet got if_done at %0d want none", il);
    end
  endtask

  task automatic test_tie();
    bit df;
    df = model_d_first_on_tie();
    if (df) begin
      model_access(1, 0, 8'h07, 32'h0, e_ddat, e_derr);
      model_access(0, 0, 8'h03, 32'h0, e_idat, e_ierr);
    end else begin
      model_access(0, 0, 8'h03, 32'h0, e_idat, e_ierr);
      model_access(1, 0, 8'h07, 32'h0, e_ddat, e_derr);
    end
    drive(1, 8'h03, 1, 0, 8'h07, 32'h0, il, dl, idat, ddat, ierr, derr, nrd, nwr, nbusy,
          clash, saddr, swd);
    n_vec++; if (dl !== (df ? 3 : 7) || il !== (df ? 7 : 3)) begin
      n_err++; $display("FAIL tie_order got d=%0d if=%0d want d=%0d if=%0d", dl, il,
                        df ? 3 : 7, df ? 7 : 3);
    end
    n_vec++; if (idat !== e_idat || ddat !== e_ddat || clash) begin
      n_err++; $display("FAIL tie_data got if=%h d=%h clash=%0b want if=%h d=%h clash=0",
                        idat, ddat, clash, e_idat, e_ddat);
    end
  endtask

  task automatic test_out_of_range();
    model_access(1, 0, 8'h80, 32'h0, e_ddat, e_derr);
    drive(0, 8'h00, 1, 0, 8'h80, 32'h0, il, dl, idat, ddat, ierr, derr, nrd, nwr, nbusy,
          clash, saddr, swd);
    n_vec++; if (nrd !== 0 || nwr !== 0 || dl !== 3) begin
      n_err++; $display("FAIL oor_read_strobes got rd=%0d wr=%0d lat=%0d want 0/0/3", nrd, nwr, dl);
    end
    n_vec++; if (derr !== 1'b1 || ddat !== e_ddat) begin
      n_err++; $display("FAIL oor_read_result got err=%0b data=%h want err=1 data=%h", derr, ddat,
                        e_ddat);
    end
    model_access(1, 1, 8'hF0, 32'h1234_5678, e_ddat, e_derr);
    drive(0, 8'h00, 1, 1, 8'hF0, 32'h1234_5678, il, dl, idat, ddat, ierr, derr, nrd, nwr,
          nbusy, clash, saddr, swd);
    n_vec++; if (nwr !== 0 || derr !== 1'b1 || ddat !== e_ddat || dl !== 3) begin
      n_err++; $display("FAIL oor_write got wr=%0d err=%0b data=%h lat=%0d want 0/1/%h/3", nwr,
                        derr, ddat, dl, e_ddat);
    end
  endtask

  task automatic test_latency4();
    int lat, nb, nw, nr;
    logic [31:0] dat;
    lat = -1; nb = 0; nw = 0; nr = 0; dat = '0;
    @(negedge clock);
    if_req4 = 1; if_addr4 = 8'h02;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (busy4) nb++;
      if (memRead4) nr++;
      if (busy4 && !memRead4 && !memWrite4 && !if_done4) nw++;
      if (if_done4) begin lat = i; dat = if_rdata4; if_req4 = 0; break; end
    end
    if_req4 = 0;
    n_vec++; if (lat !== 6 || nb !== 6) begin
      n_err++; $display("FAIL lat4_timing got lat=%0d busy=%0d want 6/6", lat, nb);
    end
    n_vec++; if (nw !== 4 || nr !== 1) begin
      n_err++; $display("FAIL lat4_wait got wait=%0d rd=%0d want 4/1", nw, nr);
    end
    n_vec++; if (dat !== 32'hA5A5_0002) begin
      n_err++; $display("FAIL lat4_data got %h want a5a50002", dat);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clock);
    d_req = 1; d_we = 0; d_addr = 8'h05;
    @(negedge clock);
    @(negedge clock);
    reset_n = 0;
    @(negedge clock);
    n_vec++;
    if ({memRead, memWrite, if_done, d_done, addr_err, busy, memaddress, invalue, if_rdata,
         d_rdata} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs got %h want 0", {memRead, memWrite, if_done, d_done,
               addr_err, busy, memaddress, invalue, if_rdata, d_rdata});
    end
    d_req = 0; reset_n = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (d_done) seen++;
    end
    n_vec++; if (seen !== 0) begin
      n_err++; $display("FAIL midreset_no_done got %0d pulses want 0", seen);
    end
    model_access(1, 0, 8'h05, 32'h0, e_ddat, e_derr);
    drive(0, 8'h00, 1, 0, 8'h05, 32'h0, il, dl, idat, ddat, ierr, derr, nrd, nwr, nbusy,
          clash, saddr, swd);
    n_vec++; if (dl !== 3 || ddat !== e_ddat) begin
      n_err++; $display("FAIL midreset_fresh got lat=%0d data=%h want 3/%h", dl, ddat, e_ddat);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      int kind, e_il, e_dl, ers, ews;
      bit ifr, dr, dwe, df;
      logic [7:0] ia, da;
      logic [31:0] wd;
      kind = $urandom_range(0, 3);
      ifr = (kind >= 2);
      dr = (kind != 2);
      dwe = (kind == 0) || (kind == 3 && $urandom_range(0, 1) == 1);
      ia = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
      da = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 15));
      wd = $urandom;
      df = (ifr && dr) ? model_d_first_on_tie() : dr;
      e_il = -1; e_dl = -1; ers = 0; ews = 0;
      if (ifr && dr) begin
        e_dl = df ? 3 : 7; e_il = df ? 7 : 3;
      end else if (dr) begin
        e_dl = 3;
      end else begin
        e_il = 3;
      end
      if (dr && df) model_access(1, dwe, da, wd, e_ddat, e_derr);
      if (ifr) model_access(0, 0, ia, 32'h0, e_idat, e_ierr);
      if (dr && !df) model_access(1, dwe, da, wd, e_ddat, e_derr);
      if (ifr && ia < 8'd128) ers++;
      if (dr && da < 8'd128) begin if (dwe) ews++; else ers++; end
      drive(ifr, ia, dr, dwe, da, wd, il, dl, idat, ddat, ierr, derr, nrd, nwr, nbusy, clash,
            saddr, swd);
      n_vec++; if (il !== e_il || dl !== e_dl || clash) begin
        n_err++; $display("FAIL rand%0d_timing got if=%0d d=%0d clash=%0b want if=%0d d=%0d", t,
                          il, dl, clash, e_il, e_dl);
      end
      n_vec++; if (nrd !== ers || nwr !== ews) begin
        n_err++; $display("FAIL rand%0d_strobes got rd=%0d wr=%0d want rd=%0d wr=%0d", t, nrd,
                          nwr, ers, ews);
      end
      if (ifr) begin
        n_vec++; if (idat !== e_idat || ierr !== e_ierr) begin
          n_err++; $display("FAIL rand%0d_if got %h err=%0b want %h err=%0b", t, idat, ierr,
                            e_idat, e_ierr);
        end
      end
      if (dr) begin
        n_vec++; if (ddat !== e_ddat || derr !== e_derr) begin
          n_err++; $display("FAIL rand%0d_d got %h err=%0b want %h err=%0b", t, ddat, derr,
                            e_ddat, e_derr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_readback();
    test_tie();
    test_out_of_range();
    test_latency4();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
